vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz).
- H_SYNC, 96: horizontal sync length in pixels.
- H_BP, 48: horizontal back porch in pixels.
- H_ACT, 640: horizontal active pixels.
- H_FP, 16: horizontal front porch in pixels.
- V_SYNC, 2: vertical sync length in lines.
- V_BP, 33: vertical back porch in lines.
- V_ACT, 480: vertical active lines.
- V_FP, 10: vertical front porch in lines.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1: system clock. The block uses one clock; reset is asynchronous and active-high.
- rst, input, 1: asynchronous active-high reset.
- pix_en, output, 1: one-clk strobe every CLK_DIV clocks.
- hc, output, 10: absolute horizontal count, 0..799, where 0 is the start of hsync.
- vc, output, 10: absolute vertical count, 0..524, where 0 is the start of vsync.
- hsync, output, 1: active-low horizontal sync.
- vsync, output, 1: active-low vertical sync.
- disp_on, output, 1: high when the pixel is in the active window.
- line_start, output, 1: one-clk strobe when hc wraps to 0.
- frame_start, output, 1: one-clk strobe when hc=0 and vc=0.

Function
REQ-003 A divider counter SHALL count 0..CLK_DIV-1. pix_en SHALL be high for the single clk in which the divider equals CLK_DIV-1.
REQ-004 hc SHALL increment only in cycles where pix_en is high. It SHALL wrap from H_TOTAL-1 (799) to 0. H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP.
REQ-005 vc SHALL increment only on a pix_en cycle in which hc wraps. It SHALL wrap from V_TOTAL-1 (524) to 0. V_TOTAL = V_SYNC+V_BP+V_ACT+V_FP.
REQ-006 A horizontal phase FSM with states H_S_SYNC, H_S_BP, H_S_ACT and H_S_FP SHALL advance at these hc boundaries: 96, 144, 784 and 800→0.
REQ-007 A vertical phase FSM with states V_S_SYNC, V_S_BP, V_S_ACT and V_S_FP SHALL advance at these vc boundaries: 2, 35, 515 and 525→0.
REQ-008 FSM transitions SHALL occur in the same clk as the counter update that crosses the boundary. Phase state and counters SHALL never disagree.
REQ-009 hsync SHALL be 0 exactly while the H FSM is in H_S_SYNC (hc 0..95), and 1 otherwise.
REQ-010 vsync SHALL be 0 exactly while the V FSM is in V_S_SYNC (vc 0..1), and 1 otherwise.
REQ-011 disp_on SHALL be 1 exactly when H is in H_S_ACT and V is in V_S_ACT, i.e. hc 144..783 and vc 35..514.
REQ-012 All outputs SHALL be registered. hsync, vsync, disp_on, hc and vc SHALL change in the same clk, with zero skew between them.
REQ-013 line_start SHALL pulse for one clk, coincident with hc becoming 0.
REQ-014 frame_start SHALL pulse for one clk, coincident with hc and vc both becoming 0. In that cycle line_start SHALL also be high.
REQ-015 Counter arithmetic SHALL be 10-bit unsigned. The comparisons that drive the wraps SHALL be equality, never overflow.
REQ-016 CLK_DIV=1 SHALL be legal; in that case pix_en SHALL be held at 1.

Reset
REQ-017 While rst is high, the block SHALL hold:
- divider=0, hc=0, vc=0.
- H FSM in H_S_SYNC, V FSM in V_S_SYNC.
- hsync=0, vsync=0, disp_on=0, pix_en=0, line_start=0, frame_start=0.
REQ-018 Reset asserted mid-frame SHALL take effect asynchronously within the same clk, with no partial line completed.
REQ-019 After rst deasserts, the first pix_en SHALL occur at the CLK_DIV-th rising clk edge.
REQ-020 Counting SHALL resume from hc=0, vc=0 without emitting frame_start for that initial position.

Structure
REQ-021 A shared package SHALL hold:
- the H/V phase enum typedef;
- H_TOTAL and V_TOTAL;
- the derived boundary constants: H_ACT_START=144, H_ACT_END=784, V_ACT_START=35, V_ACT_END=515.
REQ-022 One sub-module, vga_axis_timer, SHALL implement the counter plus phase FSM. It SHALL be instantiated twice, once for H and once for V. The V instance's enable SHALL be the H instance's wrap output.

Verification
REQ-023 Reset then run 4 clk: pix_en is high only on clk 4, and hc=1 after that edge.
REQ-024 Run one line: hsync is low for 96 pix_en cycles, and disp_on is high for exactly 640 consecutive pix_en cycles starting at hc=144.
REQ-025 Run one full frame: frame_start pulses exactly once per 800×525×4 = 1,680,000 clk, and line_start pulses exactly 525 times.
REQ-026 At hc=799 and vc=524 with pix_en: the next values are hc=0, vc=0, frame_start=1, line_start=1, hsync=0 and vsync=0.
REQ-027 Assert rst at hc=500, vc=300 for 1 clk: all outputs match REQ-017 immediately, and no disp_on glitch follows.
REQ-028 Override CLK_DIV=1: pix_en is held at 1, hc advances every clk, and one frame takes 420,000 clk.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default-mode constants for the VGA timing generator.
// The default mode is 640x480 at 60 Hz with a 25 MHz pixel clock.
package vga_timing_gen_pkg;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_e;

  // Axis-specific names for the shared phase encoding.
  localparam phase_e H_S_SYNC = PH_SYNC;
  localparam phase_e H_S_BP   = PH_BP;
  localparam phase_e H_S_ACT  = PH_ACT;
  localparam phase_e H_S_FP   = PH_FP;
  localparam phase_e V_S_SYNC = PH_SYNC;
  localparam phase_e V_S_BP   = PH_BP;
  localparam phase_e V_S_ACT  = PH_ACT;
  localparam phase_e V_S_FP   = PH_FP;

  localparam int H_TOTAL     = 96 + 48 + 640 + 16;
  localparam int V_TOTAL     = 2 + 33 + 480 + 10;
  localparam int H_ACT_START = 96 + 48;
  localparam int H_ACT_END   = 96 + 48 + 640;
  localparam int V_ACT_START = 2 + 33;
  localparam int V_ACT_END   = 2 + 33 + 480;

  function automatic int axis_total(input int sync_len, input int bp_len,
                                    input int act_len, input int fp_len);
    return sync_len + bp_len + act_len + fp_len;
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One display axis: a wrapping position counter with its sync/porch/active phase FSM.
// Used for both the horizontal (pixel) and vertical (line) axes.
module vga_axis_timer
  import vga_timing_gen_pkg::*;
#(
  parameter int SYNC = 96,
  parameter int BP   = 48,
  parameter int ACT  = 640,
  parameter int FP   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [9:0] count_o,
  output phase_e     phase_nxt_o,
  output logic       sync_n_o,
  output logic       wrap_o
);

  localparam int         TOTAL     = axis_total(SYNC, BP, ACT, FP);
  localparam logic [9:0] LAST      = 10'(TOTAL - 1);
  localparam logic [9:0] SYNC_LAST = 10'(SYNC - 1);
  localparam logic [9:0] BP_LAST   = 10'(SYNC + BP - 1);
  localparam logic [9:0] ACT_LAST  = 10'(SYNC + BP + ACT - 1);

  logic [9:0] count_q, count_d;
  phase_e     phase_q, phase_d;
  logic       sync_n_q;
  logic       wrap;

  assign wrap = en_i && (count_q == LAST);

  // Phase moves on the same enable as the counter, keyed off the count it is leaving.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (en_i) begin
      count_d = wrap ? 10'd0 : count_q + 10'd1;
      case (phase_q)
        PH_SYNC: if (count_q == SYNC_LAST) phase_d = PH_BP;
        PH_BP:   if (count_q == BP_LAST)   phase_d = PH_ACT;
        PH_ACT:  if (count_q == ACT_LAST)  phase_d = PH_FP;
        PH_FP:   if (wrap)                 phase_d = PH_SYNC;
        default: phase_d = PH_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 10'd0;
      phase_q  <= PH_SYNC;
      sync_n_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      sync_n_q <= (phase_d != PH_SYNC);
    end
  end

  assign count_o     = count_q;
  assign phase_nxt_o = phase_d;
  assign sync_n_o    = sync_n_q;
  assign wrap_o      = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider feeding a horizontal and a vertical axis timer.
// Every output is a flop so counters, syncs and disp_on change on the same edge.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       disp_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, line_start_q, frame_start_q, disp_on_q;
  logic             h_wrap, v_wrap;
  phase_e           h_phase_nxt, v_phase_nxt;

  assign div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

  vga_axis_timer #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)
  ) u_h_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (pix_en_q),
    .count_o     (hc),
    .phase_nxt_o (h_phase_nxt),
    .sync_n_o    (hsync),
    .wrap_o      (h_wrap)
  );

  // Lines advance only on the pixel tick that wraps the horizontal counter.
  vga_axis_timer #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)
  ) u_v_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (h_wrap),
    .count_o     (vc),
    .phase_nxt_o (v_phase_nxt),
    .sync_n_o    (vsync),
    .wrap_o      (v_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      disp_on_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= (div_d == DIV_LAST);
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      disp_on_q     <= (h_phase_nxt == H_S_ACT) && (v_phase_nxt == V_S_ACT);
    end
  end

  assign pix_en      = pix_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign disp_on     = disp_on_q;

endmodule
